// File: rtl/clk_pkg.sv
// Shared clock-domain helpers: FSM encoding and default counter width for
// the clock monitor and the clock divider.
package clk_pkg;
  localparam int CLK_CNT_W = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } clk_state_e;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a rising-edge detector.
module sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/clk_mon.sv
// Clock monitor: measures period and high time of a slow clock in clk_in
// cycles, reports lock after repeated equal periods, and flags a stalled input.
module clk_mon
  import clk_pkg::*;
#(
  parameter int CNT_W       = CLK_CNT_W,
  parameter int LOCK_N      = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);
  localparam int               MC_W      = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
  localparam logic [MC_W-1:0]  MATCH_MAX = MC_W'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT_CYC);

  clk_state_e       state, state_nxt;
  logic             s2, rise, at_to, do_meas, do_to;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [MC_W-1:0]  match_cnt;

  sync_edge u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .q      (s2),
    .rise   (rise)
  );

  assign at_to = (per_cnt == TO_VAL);

  always_ff @(posedge clk_in) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (rise) state_nxt = ST_MEASURE;
      ST_MEASURE: if (!rise && at_to) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // A rise always beats a simultaneous timeout.
  always_comb begin
    do_meas = 1'b0;
    do_to   = 1'b0;
    if (rise) do_meas = (state == ST_MEASURE);
    else      do_to   = at_to;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= do_meas;
      timeout    <= do_to;

      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(s2);
      end else if (do_to) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= '0;
      end else begin
        per_cnt <= per_cnt + CNT_W'(1);
        if (state == ST_MEASURE) hi_cnt <= hi_cnt + CNT_W'(s2);
      end

      // Lock tracks runs of periods equal to the one held in the output register.
      if (do_meas) begin
        period    <= per_cnt;
        high_time <= hi_cnt;
        if (per_cnt == period) begin
          if (match_cnt == MATCH_MAX) locked <= 1'b1;
          else                        match_cnt <= match_cnt + MC_W'(1);
        end else begin
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      end else if (do_to) begin
        match_cnt <= '0;
        locked    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: directed waveforms, a history-based reference model
// checked every cycle, plus hand-computed spot checks.
module tb_clk_mon;
  localparam int CNT_W = 16;
  localparam int LOCK_N = 4;
  localparam int TO = 20;
  localparam int HN = 8192;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic meas_valid, locked, timeout;

  int compared = 0;
  int mismatched = 0;

  clk_mon #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .TIMEOUT_CYC(TO)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: keeps the sampled input history per clock edge and derives
  // rises, periods, high counts and lock from it arithmetically.
  bit hist [0:HN-1];
  int cyc = 0;
  bit started = 1'b0;
  bit armed = 1'b0;
  int rise_edge = 0, restart = 0, eq_run = 0;
  int e_per = 0, e_hi = 0;
  bit e_mv = 1'b0, e_lock = 1'b0, e_to = 1'b0;

  always @(posedge clk_in) begin
    int k, p, h;
    bit rz;
    cyc = cyc + 1;
    k = cyc;
    hist[k] = sig_in;
    if (rst) begin
      started = 1'b1;
      for (int j = 0; j < 3; j++) if (k - j >= 0) hist[k-j] = 1'b0;
      armed = 1'b0; restart = k + 1; eq_run = 0;
      e_per = 0; e_hi = 0; e_mv = 1'b0; e_lock = 1'b0; e_to = 1'b0;
    end else if (started) begin
      e_mv = 1'b0;
      e_to = 1'b0;
      rz = (k >= 3) && hist[k-2] && !hist[k-3];
      if (rz) begin
        if (armed) begin
          p = k - rise_edge;
          h = 0;
          for (int j = rise_edge; j < k; j++) h += int'(hist[j-2]);
          if (p == e_per) eq_run++;
          else            eq_run = 0;
          e_per = p; e_hi = h; e_mv = 1'b1;
          e_lock = (eq_run >= LOCK_N);
        end
        armed = 1'b1; rise_edge = k; restart = k;
      end else if (k - restart == TO) begin
        e_to = 1'b1; armed = 1'b0; e_lock = 1'b0; eq_run = 0; restart = k;
      end
    end
  end

  // Per-cycle compare and event bookkeeping from observed outputs.
  int mv_cnt = 0, last_mv_cyc = 0, to_cnt = 0, lock_mv = 0;
  bit seen7 = 1'b0, lock_at7 = 1'b0, lock_seen = 1'b0;

  always @(negedge clk_in) begin
    if (started) begin
      compared++;
      if (period !== CNT_W'(e_per) || high_time !== CNT_W'(e_hi) || meas_valid !== e_mv ||
          locked !== e_lock || timeout !== e_to) begin
        mismatched++;
        $display("FAIL model cyc %0d: got per=%0d hi=%0d mv=%b lk=%b to=%b, want per=%0d hi=%0d mv=%b lk=%b to=%b",
                 cyc, period, high_time, meas_valid, locked, timeout, e_per, e_hi, e_mv, e_lock, e_to);
      end
      if (meas_valid === 1'b1) begin
        mv_cnt++;
        last_mv_cyc = cyc;
        if (period == 7 && !seen7) begin seen7 = 1'b1; lock_at7 = locked; end
      end
      if (locked === 1'b1 && !lock_seen) begin lock_seen = 1'b1; lock_mv = mv_cnt; end
      if (timeout === 1'b1) to_cnt++;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic r);
    sig_in = s;
    rst = r;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int c = 0; c < n; c++)
      for (int i = 0; i < p; i++) step(i < h, 1'b0);
  endtask

  task automatic wait_to(input int n, output int t);
    t = -1000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (timeout === 1'b1) begin t = cyc; break; end
    end
  endtask

  initial begin
    int base, t1, t2;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_flags", {meas_valid, locked, timeout}, 0);

    // 5-cycle wave, high 2: lock on the 5th measurement (4th equal one)
    base = mv_cnt;
    wave(5, 2, 8);
    chk("p5_period", period, 5);
    chk("p5_high", high_time, 2);
    chk("p5_locked", locked, 1);
    chk("p5_lock_at_mv", lock_mv - base, 5);

    // switch to 7-cycle wave
    wave(7, 3, 7);
    chk("p7_seen", seen7, 1);
    chk("p7_first_unlocked", lock_at7, 0);
    chk("p7_period", period, 7);
    chk("p7_high", high_time, 3);
    chk("p7_relocked", locked, 1);

    // back to 5, then stall low: timeout 20 after last restart, then idle repeat
    wave(5, 2, 8);
    chk("p5b_locked", locked, 1);
    wait_to(40, t1);
    chk("to_gap", t1 - last_mv_cyc, TO);
    chk("to_period_held", period, 5);
    chk("to_unlocked", locked, 0);
    wait_to(40, t2);
    chk("idle_to_gap", t2 - t1, TO);

    // reset mid-period of a 10-cycle, 1-high wave
    wave(10, 1, 3);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high", high_time, 0);
    chk("mid_rst_flags", {meas_valid, locked, timeout}, 0);
    repeat (5) step(1'b0, 1'b0);
    base = mv_cnt;
    wave(10, 1, 4);
    chk("post_rst_mv", mv_cnt - base, 3);
    chk("p10_period", period, 10);
    chk("p10_high", high_time, 1);

    // rise coincides with the timeout count: measurement wins
    base = to_cnt;
    wave(20, 1, 4);
    chk("p20_no_timeout", to_cnt - base, 0);
    chk("p20_period", period, TO);
    chk("p20_high", high_time, 1);
    wait_to(40, t1);
    chk("p20_to_gap", t1 - last_mv_cyc, TO);

    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end
endmodule
